dcache_read_req_arbiter: RTL and testbench

- Parametrised N-input arbiter for data-cache meta/data-array read requests, each carrying up to N_SLOTS (address, way-enable) slots.
- Replaces the fixed 3-input combinational priority arbiter in front of the dcache read port.
- Adds a selectable round-robin mode, a registered output stage with full ready/valid backpressure, and a grant index output.
- Sits between the MSHR/prefetch/LSU request sources and the dcache array read pipeline.

---
 rtl/dcache_read_req_arbiter.sv | 146 ++++++++++++++
 tb/tb_dcache_read_req_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_read_req_arbiter.sv
// dcache_read_req_arbiter
// N-input arbiter in front of the dcache meta/data array read port. Each
// request carries N_SLOTS (addr, way_en) slots. One winner per cycle is
// captured into a single registered output stage with ready/valid
// backpressure. Arbitration is fixed priority or round-robin (RR_MODE).
module dcache_read_req_arbiter #(
  parameter int N_IN      = 3,
  parameter int N_SLOTS   = 2,
  parameter int WAY_BITS  = 8,
  parameter int ADDR_BITS = 12,
  parameter bit RR_MODE   = 1'b0,
  localparam int CHOSEN_BITS = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N_IN-1:0]                   io_in_valid,
  output logic [N_IN-1:0]                   io_in_ready,
  input  logic [N_IN*N_SLOTS*WAY_BITS-1:0]  io_in_bits_way_en,
  input  logic [N_IN*N_SLOTS*ADDR_BITS-1:0] io_in_bits_addr,
  input  logic [N_IN*N_SLOTS-1:0]           io_in_bits_slot_valid,
  output logic                              io_out_valid,
  input  logic                              io_out_ready,
  output logic [N_SLOTS*WAY_BITS-1:0]       io_out_bits_way_en,
  output logic [N_SLOTS*ADDR_BITS-1:0]      io_out_bits_addr,
  output logic [N_SLOTS-1:0]                io_out_bits_slot_valid,
  output logic [CHOSEN_BITS-1:0]            io_out_chosen
);

  logic                         out_valid_q;
  logic [N_SLOTS*WAY_BITS-1:0]  out_way_en_q;
  logic [N_SLOTS*ADDR_BITS-1:0] out_addr_q;
  logic [N_SLOTS-1:0]           out_slot_valid_q;
  logic [CHOSEN_BITS-1:0]       out_chosen_q;

  logic                         any_valid;
  logic                         can_load;
  logic                         load;
  logic [CHOSEN_BITS-1:0]       grant;

  logic [N_SLOTS*WAY_BITS-1:0]  nxt_way_en;
  logic [N_SLOTS*ADDR_BITS-1:0] nxt_addr;
  logic [N_SLOTS-1:0]           nxt_slot_valid;

  assign any_valid = |io_in_valid;
  // The stage can accept when empty or when its content leaves this cycle;
  // reset blocks any handshake so nothing is accepted while it is high.
  assign can_load  = ~out_valid_q | io_out_ready;
  assign load      = can_load & any_valid & ~reset;

  generate
    if (RR_MODE) begin : g_rr
      logic [CHOSEN_BITS-1:0] rr_ptr;

      // Round-robin: first valid input strictly after rr_ptr, wrapping.
      always_comb begin
        int  idx;
        logic found;
        // NOTE: every variable assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= N_IN; off++) begin
          idx = int'(rr_ptr) + off;
          if (idx >= N_IN) idx = idx - N_IN;
          if (!found && io_in_valid[idx]) begin
            found = 1'b1;
            grant = CHOSEN_BITS'(idx);
          end
        end
      end

      // Pointer follows the last granted input; reset value makes input 0 first.
      always_ff @(posedge clock) begin
        if (reset) begin
          rr_ptr <= CHOSEN_BITS'(N_IN - 1);
        end else if (load) begin
          rr_ptr <= grant;
        end
      end
    end else begin : g_fixed
      // Fixed priority: lowest valid index wins (scan downward so it lands last).
      always_comb begin
        grant = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
          if (io_in_valid[i]) grant = CHOSEN_BITS'(i);
        end
      end
    end
  endgenerate

  // Only the granted input sees ready, and only when a load can happen.
  always_comb begin
    io_in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      io_in_ready[i] = load && (int'(grant) == i);
    end
  end

  // Select the granted input's slots, zeroing the fields of invalid slots.
  always_comb begin
    int gi;
    int base;
    nxt_way_en     = '0;
    nxt_addr       = '0;
    nxt_slot_valid = '0;
    gi   = int'(grant);
    base = 0;
    for (int s = 0; s < N_SLOTS; s++) begin
      base = gi * N_SLOTS + s;
      nxt_slot_valid[s] = io_in_bits_slot_valid[base];
      if (io_in_bits_slot_valid[base]) begin
        nxt_way_en[s*WAY_BITS +: WAY_BITS]   = io_in_bits_way_en[base*WAY_BITS +: WAY_BITS];
        nxt_addr[s*ADDR_BITS +: ADDR_BITS]   = io_in_bits_addr[base*ADDR_BITS +: ADDR_BITS];
      end
    end
  end

  // Output stage: load the winner, hold under backpressure, empty on drain.
  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      out_valid_q      <= 1'b0;
      out_way_en_q     <= '0;
      out_addr_q       <= '0;
      out_slot_valid_q <= '0;
      out_chosen_q     <= '0;
    end else if (load) begin
      out_valid_q      <= 1'b1;
      out_way_en_q     <= nxt_way_en;
      out_addr_q       <= nxt_addr;
      out_slot_valid_q <= nxt_slot_valid;
      out_chosen_q     <= grant;
    end else if (io_out_ready) begin
      out_valid_q      <= 1'b0;
    end
  end

  assign io_out_valid           = out_valid_q;
  assign io_out_bits_way_en     = out_way_en_q;
  assign io_out_bits_addr       = out_addr_q;
  assign io_out_bits_slot_valid = out_slot_valid_q;
  assign io_out_chosen          = out_chosen_q;

endmodule

// File: tb/tb_dcache_read_req_arbiter.sv
// Directed bench for dcache_read_req_arbiter: a fixed-priority and a
// round-robin instance share the same stimulus and are checked side by side.
module tb_dcache_read_req_arbiter;

  localparam int N_IN = 3;
  localparam int NS   = 2;
  localparam int WB   = 8;
  localparam int AB   = 12;

  logic                   clock;
  logic                   reset;
  logic [N_IN-1:0]        in_valid;
  logic [N_IN*NS*WB-1:0]  in_way_en;
  logic [N_IN*NS*AB-1:0]  in_addr;
  logic [N_IN*NS-1:0]     in_slot_valid;
  logic                   out_ready;

  logic [N_IN-1:0]  fp_in_ready,  rr_in_ready;
  logic             fp_out_valid, rr_out_valid;
  logic [NS*WB-1:0] fp_way_en,    rr_way_en;
  logic [NS*AB-1:0] fp_addr,      rr_addr;
  logic [NS-1:0]    fp_slot_valid, rr_slot_valid;
  logic [1:0]       fp_chosen,    rr_chosen;

  int total = 0;
  int bad   = 0;

  dcache_read_req_arbiter #(.N_IN(N_IN), .N_SLOTS(NS), .WAY_BITS(WB), .ADDR_BITS(AB), .RR_MODE(1'b0)) u_fp (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(fp_in_ready),
    .io_in_bits_way_en(in_way_en), .io_in_bits_addr(in_addr),
    .io_in_bits_slot_valid(in_slot_valid),
    .io_out_valid(fp_out_valid), .io_out_ready(out_ready),
    .io_out_bits_way_en(fp_way_en), .io_out_bits_addr(fp_addr),
    .io_out_bits_slot_valid(fp_slot_valid), .io_out_chosen(fp_chosen)
  );

  dcache_read_req_arbiter #(.N_IN(N_IN), .N_SLOTS(NS), .WAY_BITS(WB), .ADDR_BITS(AB), .RR_MODE(1'b1)) u_rr (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(rr_in_ready),
    .io_in_bits_way_en(in_way_en), .io_in_bits_addr(in_addr),
    .io_in_bits_slot_valid(in_slot_valid),
    .io_out_valid(rr_out_valid), .io_out_ready(out_ready),
    .io_out_bits_way_en(rr_way_en), .io_out_bits_addr(rr_addr),
    .io_out_bits_slot_valid(rr_slot_valid), .io_out_chosen(rr_chosen)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (obs=timeout exp=finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input int i, input logic [1:0] sv,
                        input logic [7:0] w0, input logic [11:0] a0,
                        input logic [7:0] w1, input logic [11:0] a1);
    in_slot_valid[i*NS +: NS] = sv;
    in_way_en[i*NS*WB      +: WB] = w0;
    in_way_en[i*NS*WB + WB +: WB] = w1;
    in_addr[i*NS*AB      +: AB] = a0;
    in_addr[i*NS*AB + AB +: AB] = a1;
  endtask

  task automatic chk_out(input string tag, input int c, input logic [23:0] a, input logic [15:0] w);
    chk({tag, "_fp_valid"},  32'(fp_out_valid), 32'd1);
    chk({tag, "_fp_chosen"}, 32'(fp_chosen), 32'(c));
    chk({tag, "_fp_addr"},   32'(fp_addr), 32'(a));
    chk({tag, "_fp_way"},    32'(fp_way_en), 32'(w));
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; in_way_en = '0; in_addr = '0;
    in_slot_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < N_IN; i++)
      set_in(i, 2'b11, 8'h01 << i, 12'h100 + 12'(i), 8'h10 << i, 12'h200 + 12'(i));

    // Reset state, and valid during reset is ignored.
    step(); step();
    chk("rst_fp_valid",  32'(fp_out_valid), 32'd0);
    chk("rst_fp_chosen", 32'(fp_chosen), 32'd0);
    chk("rst_fp_addr",   32'(fp_addr), 32'd0);
    chk("rst_rr_valid",  32'(rr_out_valid), 32'd0);
    in_valid = 3'b111; out_ready = 1'b1; #1;
    chk("rst_fp_ready", 32'(fp_in_ready), 32'd0);
    chk("rst_rr_ready", 32'(rr_in_ready), 32'd0);
    step();
    chk("rst_hold_valid", 32'(fp_out_valid), 32'd0);

    // Release reset with all inputs valid: fixed stays on 0, RR rotates.
    reset = 1'b0; #1;
    chk("p0_fp_ready", 32'(fp_in_ready), 32'b001);
    chk("p0_rr_ready", 32'(rr_in_ready), 32'b001);
    step();
    chk_out("fp_a", 0, 24'h200100, 16'h1001);
    chk("rr_a_chosen", 32'(rr_chosen), 32'd0);
    chk("rr_a_ready", 32'(rr_in_ready), 32'b010);
    step();
    chk("fp_b_chosen", 32'(fp_chosen), 32'd0);
    chk("rr_b_chosen", 32'(rr_chosen), 32'd1);
    chk("rr_b_addr",   32'(rr_addr), 32'h201101);
    chk("rr_b_ready",  32'(rr_in_ready), 32'b100);
    step();
    chk("fp_c_chosen", 32'(fp_chosen), 32'd0);
    chk("rr_c_chosen", 32'(rr_chosen), 32'd2);
    chk("rr_c_way",    32'(rr_way_en), 32'h4004);
    step();
    chk("rr_d_chosen", 32'(rr_chosen), 32'd0);
    step();
    chk("rr_e_chosen", 32'(rr_chosen), 32'd1);
    step();
    chk("rr_f_chosen", 32'(rr_chosen), 32'd2);
    chk("rr_f_valid",  32'(rr_out_valid), 32'd1);

    // Drop input 0: both pick input 1.
    in_valid = 3'b110; #1;
    chk("drop0_fp_ready", 32'(fp_in_ready), 32'b010);
    chk("drop0_rr_ready", 32'(rr_in_ready), 32'b010);
    step();
    chk("drop0_fp_chosen", 32'(fp_chosen), 32'd1);
    chk("drop0_rr_chosen", 32'(rr_chosen), 32'd1);

    // Backpressure: load input 1, then hold for 4 cycles.
    set_in(1, 2'b11, 8'h10, 12'h0A5, 8'h02, 12'h3C3);
    in_valid = 3'b010;
    step();
    chk_out("bp_load", 1, 24'h3C30A5, 16'h0210);
    out_ready = 1'b0; in_valid = 3'b101; #1;
    chk("bp_fp_ready0", 32'(fp_in_ready), 32'd0);
    chk("bp_rr_ready0", 32'(rr_in_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_out("bp_hold", 1, 24'h3C30A5, 16'h0210);
      chk("bp_hold_rr_chosen", 32'(rr_chosen), 32'd1);
      chk("bp_hold_fp_ready", 32'(fp_in_ready), 32'd0);
      chk("bp_hold_rr_ready", 32'(rr_in_ready), 32'd0);
    end
    out_ready = 1'b1; #1;
    chk("bp_rel_fp_ready", 32'(fp_in_ready), 32'b001);
    chk("bp_rel_rr_ready", 32'(rr_in_ready), 32'b100);
    step();
    chk_out("bp_next", 0, 24'h200100, 16'h1001);
    chk("bp_next_rr_chosen", 32'(rr_chosen), 32'd2);

    // Slot masking on input 2.
    set_in(2, 2'b01, 8'h04, 12'h123, 8'hFF, 12'hFFF);
    in_valid = 3'b100;
    step();
    chk_out("mask", 2, 24'h000123, 16'h0004);
    chk("mask_sv", 32'(fp_slot_valid), 32'b01);
    chk("mask_rr_addr", 32'(rr_addr), 32'h000123);

    // All slots invalid: still accepted and forwarded.
    set_in(2, 2'b00, 8'hAA, 12'h555, 8'hBB, 12'h666);
    step();
    chk_out("empty_req", 2, 24'h0, 16'h0);
    chk("empty_req_sv", 32'(fp_slot_valid), 32'b00);

    // Idle: drain, then nothing for 5 cycles.
    in_valid = 3'b000; #1;
    chk("idle_fp_ready", 32'(fp_in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("idle_fp_valid", 32'(fp_out_valid), 32'd0);
      chk("idle_rr_valid", 32'(rr_out_valid), 32'd0);
      chk("idle_fp_ready", 32'(fp_in_ready), 32'd0);
      chk("idle_rr_ready", 32'(rr_in_ready), 32'd0);
    end

    // Reset mid-operation with a held request.
    in_valid = 3'b010;
    step();
    chk("mid_rr_chosen", 32'(rr_chosen), 32'd1);
    out_ready = 1'b0; in_valid = 3'b111;
    step();
    chk("mid_hold_valid", 32'(rr_out_valid), 32'd1);
    chk("mid_hold_chosen", 32'(fp_chosen), 32'd1);
    reset = 1'b1; #1;
    chk("mid_rst_ready", 32'(rr_in_ready), 32'd0);
    step();
    chk("mid_rst_fp_valid", 32'(fp_out_valid), 32'd0);
    chk("mid_rst_rr_valid", 32'(rr_out_valid), 32'd0);
    chk("mid_rst_fp_chosen", 32'(fp_chosen), 32'd0);
    chk("mid_rst_rr_chosen", 32'(rr_chosen), 32'd0);
    reset = 1'b0; out_ready = 1'b1; #1;
    chk("post_rst_rr_ready", 32'(rr_in_ready), 32'b001);
    step();
    chk("post_rst_rr_chosen", 32'(rr_chosen), 32'd0);
    chk("post_rst_rr_valid", 32'(rr_out_valid), 32'd1);
    chk("post_rst_fp_chosen", 32'(fp_chosen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
